alu_host: RTL and testbench

Command-driven initiator for the ALU pin interface. It buffers operation requests in a small command FIFO and drives the ALU's enable, opcode and operand pins for exactly one cycle per operation. It then captures `alu_out` and `alu_irq`, pulses `alu_irq_clr` when an interrupt was raised, and returns one in-order response per command over a valid/ready channel. It sits between a host-side requester (test sequencer or bus bridge) and the ALU, and owns the ALU side of the interface.

---
 rtl/alu_host.sv | 197 +++++++++++++++++++
 tb/tb_alu_host.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_host.sv
// Command-driven initiator for the ALU pin interface: queues host commands,
// issues one ALU operation at a time and returns in-order responses.
package alu_pkg;
    typedef enum logic [1:0] {OP1 = 2'd0, OP2 = 2'd1, OP3 = 2'd2, OP4 = 2'd3} opcode_t;
    typedef logic [7:0] data_t;
    typedef struct packed {
        logic    mode;
        opcode_t op;
        data_t   a;
        data_t   b;
    } cmd_t;
endpackage

module alu_host
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned IRQ_CLR_CYCLES = 2
) (
    input  logic                   alu_clk,
    input  logic                   alu_rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_mode,
    input  opcode_t                cmd_op,
    input  data_t                  cmd_a,
    input  data_t                  cmd_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output data_t                  rsp_data,
    output logic                   rsp_irq,
    output logic                   rsp_mode,
    output opcode_t                rsp_op,
    output logic                   alu_enable,
    output logic                   alu_enable_a,
    output logic                   alu_enable_b,
    output opcode_t                alu_op_a,
    output opcode_t                alu_op_b,
    output data_t                  alu_in_a,
    output data_t                  alu_in_b,
    output logic                   alu_irq_clr,
    input  data_t                  alu_out,
    input  logic                   alu_irq,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] cmd_count,
    output logic [7:0]             irq_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CLR_W = 4;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_CLEAR, S_RESP} state_t;

    state_t             r_state;
    cmd_t               r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_cmd_ready;
    logic               r_cur_mode;
    opcode_t            r_cur_op;
    logic [CLR_W-1:0]   r_clr_cnt;

    cmd_t               w_cmd_in;
    cmd_t               w_head;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_nxt;

    assign w_cmd_in  = {cmd_mode, cmd_op, cmd_a, cmd_b};
    assign w_head    = r_mem[r_rd_ptr];
    assign w_push    = cmd_valid && r_cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign cmd_ready = r_cmd_ready;
    assign cmd_count = r_count;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // FIFO storage carries no reset; occupancy and pointers do.
    always_ff @(posedge alu_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    always_ff @(posedge alu_clk or negedge alu_rst_n) begin
        if (!alu_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt != CNT_W'(DEPTH));
        end
    end

    // Operation sequencer; every ALU-side and response output is registered here.
    always_ff @(posedge alu_clk or negedge alu_rst_n) begin
        if (!alu_rst_n) begin
            r_state      <= S_IDLE;
            r_cur_mode   <= 1'b0;
            r_cur_op     <= OP1;
            r_clr_cnt    <= '0;
            alu_enable   <= 1'b0;
            alu_enable_a <= 1'b0;
            alu_enable_b <= 1'b0;
            alu_op_a     <= OP1;
            alu_op_b     <= OP1;
            alu_in_a     <= '0;
            alu_in_b     <= '0;
            alu_irq_clr  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_irq      <= 1'b0;
            rsp_mode     <= 1'b0;
            rsp_op       <= OP1;
            busy         <= 1'b0;
            irq_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state      <= S_ISSUE;
                        busy         <= 1'b1;
                        r_cur_mode   <= w_head.mode;
                        r_cur_op     <= w_head.op;
                        alu_enable   <= 1'b1;
                        alu_enable_a <= !w_head.mode;
                        alu_enable_b <= w_head.mode;
                        alu_op_a     <= w_head.mode ? OP1 : w_head.op;
                        alu_op_b     <= w_head.mode ? w_head.op : OP1;
                        alu_in_a     <= w_head.a;
                        alu_in_b     <= w_head.b;
                    end
                end
                S_ISSUE: begin
                    r_state      <= S_CAPTURE;
                    alu_enable   <= 1'b0;
                    alu_enable_a <= 1'b0;
                    alu_enable_b <= 1'b0;
                    alu_op_a     <= OP1;
                    alu_op_b     <= OP1;
                    alu_in_a     <= '0;
                    alu_in_b     <= '0;
                end
                S_CAPTURE: begin
                    rsp_data <= alu_out;
                    rsp_irq  <= alu_irq;
                    rsp_mode <= r_cur_mode;
                    rsp_op   <= r_cur_op;
                    if (alu_irq) begin
                        r_state     <= S_CLEAR;
                        alu_irq_clr <= 1'b1;
                        r_clr_cnt   <= CLR_W'(IRQ_CLR_CYCLES - 1);
                        if (irq_count != 8'hFF) irq_count <= irq_count + 8'd1;
                    end else begin
                        r_state   <= S_RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == '0) begin
                        r_state     <= S_RESP;
                        alu_irq_clr <= 1'b0;
                        rsp_valid   <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt - CLR_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state   <= S_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_host.sv
// Directed bench for alu_host with a small behavioural ALU attached to the pin side.
module tb_alu_host;
    import alu_pkg::*;

    logic       alu_clk = 1'b0;
    logic       alu_rst_n;
    logic       cmd_valid, cmd_ready, cmd_mode;
    opcode_t    cmd_op;
    data_t      cmd_a, cmd_b;
    logic       rsp_valid, rsp_ready, rsp_irq, rsp_mode;
    data_t      rsp_data;
    opcode_t    rsp_op;
    logic       alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr;
    opcode_t    alu_op_a, alu_op_b;
    data_t      alu_in_a, alu_in_b;
    data_t      alu_out;
    logic       alu_irq;
    logic       busy;
    logic [2:0] cmd_count;
    logic [7:0] irq_count;

    int n_vec = 0;
    int n_err = 0;
    int clr_hi = 0;
    int rv_hi = 0;
    int en_hi = 0;

    logic [11:0] exp_rsp [6];
    logic        b2b_mode [6];
    opcode_t     b2b_op [6];
    data_t       b2b_a [6];
    data_t       b2b_b [6];

    alu_host #(.DEPTH(4), .IRQ_CLR_CYCLES(2)) dut (
        .alu_clk(alu_clk), .alu_rst_n(alu_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_irq(rsp_irq), .rsp_mode(rsp_mode), .rsp_op(rsp_op),
        .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_irq_clr(alu_irq_clr), .alu_out(alu_out), .alu_irq(alu_irq),
        .busy(busy), .cmd_count(cmd_count), .irq_count(irq_count)
    );

    always #5 alu_clk = ~alu_clk;

    // ALU: path A OP1 saturating add (IRQ on carry), path B OP1 subtract (IRQ on borrow);
    // OP1 is guarded by b != 0. Idle cycles write 0 to the result.
    logic [8:0] m_sum;
    always @(posedge alu_clk or negedge alu_rst_n) begin
        if (!alu_rst_n) begin
            alu_out <= 8'h00;
            alu_irq <= 1'b0;
        end else begin
            if (alu_irq_clr) alu_irq <= 1'b0;
            if (alu_enable && alu_enable_a) begin
                case (alu_op_a)
                    OP1: if (alu_in_b != 8'h00) begin
                        m_sum = {1'b0, alu_in_a} + {1'b0, alu_in_b};
                        alu_out <= m_sum[8] ? 8'hFF : m_sum[7:0];
                        if (m_sum[8]) alu_irq <= 1'b1;
                    end
                    OP2: alu_out <= alu_in_a & alu_in_b;
                    OP3: alu_out <= alu_in_a | alu_in_b;
                    default: alu_out <= alu_in_a ^ alu_in_b;
                endcase
            end else if (alu_enable && alu_enable_b) begin
                case (alu_op_b)
                    OP1: if (alu_in_b != 8'h00) begin
                        alu_out <= alu_in_a - alu_in_b;
                        if (alu_in_a < alu_in_b) alu_irq <= 1'b1;
                    end
                    OP2: alu_out <= alu_in_a & alu_in_b;
                    OP3: alu_out <= alu_in_a | alu_in_b;
                    default: alu_out <= ~(alu_in_a ^ alu_in_b);
                endcase
            end else begin
                alu_out <= 8'h00;
            end
        end
    end

    always @(negedge alu_clk) begin
        if (alu_irq_clr) clr_hi++;
        if (rsp_valid) rv_hi++;
        if (alu_enable) en_hi++;
    end

    task automatic tick;
        @(posedge alu_clk);
        #1;
    endtask

    task automatic drive(input logic m, input opcode_t op, input data_t a, input data_t b);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    task automatic wait_rsp(output logic [11:0] got, output bit ok);
        ok  = 1'b0;
        got = '0;
        for (int k = 0; k < 64; k++) begin
            if (rsp_valid) begin
                got = {rsp_mode, rsp_op, rsp_irq, rsp_data};
                ok  = 1'b1;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        alu_rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_op = OP1; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
        n_vec++; if (cmd_count !== 3'd0) begin n_err++; $display("FAIL reset_cmd_count: got %0d exp 0", cmd_count); end
        n_vec++; if ({rsp_valid, busy, irq_count} !== 10'd0) begin n_err++; $display("FAIL reset_status: got %h exp 0", {rsp_valid, busy, irq_count}); end
        n_vec++; if ({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr} !== 4'd0) begin n_err++; $display("FAIL reset_alu_ctl: got %b exp 0000", {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}); end
        n_vec++; if ({alu_op_a, alu_op_b, alu_in_a, alu_in_b} !== 20'd0) begin n_err++; $display("FAIL reset_alu_bus: got %h exp 0", {alu_op_a, alu_op_b, alu_in_a, alu_in_b}); end
        n_vec++; if ({rsp_mode, rsp_op, rsp_irq, rsp_data} !== 12'd0) begin n_err++; $display("FAIL reset_rsp: got %h exp 0", {rsp_mode, rsp_op, rsp_irq, rsp_data}); end
        alu_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_path_a_op4;
        int c0;
        c0 = clr_hi;
        rsp_ready = 1'b1;
        drive(1'b0, OP4, 8'h00, 8'h5A);
        tick();                                   // E0
        cmd_valid = 1'b0;
        n_vec++; if ({busy, cmd_count} !== 4'b0001) begin n_err++; $display("FAIL a4_e0_busy_count: got %b exp 0001", {busy, cmd_count}); end
        tick();                                   // E1
        n_vec++; if ({alu_enable, alu_enable_a, alu_enable_b} !== 3'b110) begin n_err++; $display("FAIL a4_enables: got %b exp 110", {alu_enable, alu_enable_a, alu_enable_b}); end
        n_vec++; if ({alu_op_a, alu_op_b, alu_in_a, alu_in_b} !== {OP4, OP1, 8'h00, 8'h5A}) begin n_err++; $display("FAIL a4_alu_bus: got %h exp %h", {alu_op_a, alu_op_b, alu_in_a, alu_in_b}, {OP4, OP1, 8'h00, 8'h5A}); end
        n_vec++; if ({busy, cmd_count} !== 4'b1000) begin n_err++; $display("FAIL a4_e1_busy_count: got %b exp 1000", {busy, cmd_count}); end
        tick();                                   // E2
        n_vec++; if ({alu_enable, rsp_valid} !== 2'b00) begin n_err++; $display("FAIL a4_e2: got %b exp 00", {alu_enable, rsp_valid}); end
        tick();                                   // E3
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL a4_rsp_valid: got %b exp 1", rsp_valid); end
        n_vec++; if ({rsp_mode, rsp_op, rsp_irq, rsp_data} !== {1'b0, OP4, 1'b0, 8'h5A}) begin n_err++; $display("FAIL a4_rsp: got %h exp %h", {rsp_mode, rsp_op, rsp_irq, rsp_data}, {1'b0, OP4, 1'b0, 8'h5A}); end
        tick();                                   // E4
        n_vec++; if ({rsp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL a4_done: got %b exp 00", {rsp_valid, busy}); end
        n_vec++; if (clr_hi - c0 !== 0) begin n_err++; $display("FAIL a4_irq_clr_cycles: got %0d exp 0", clr_hi - c0); end
    endtask

    task automatic test_irq;
        int c0;
        c0 = clr_hi;
        rsp_ready = 1'b1;
        drive(1'b0, OP1, 8'hFF, 8'hFF);
        tick();                                   // E0
        cmd_valid = 1'b0;
        repeat (3) tick();                        // E3
        n_vec++; if ({alu_irq_clr, rsp_valid, busy} !== 3'b101) begin n_err++; $display("FAIL irq_e3: got %b exp 101", {alu_irq_clr, rsp_valid, busy}); end
        n_vec++; if (irq_count !== 8'd1) begin n_err++; $display("FAIL irq_count: got %0d exp 1", irq_count); end
        tick();                                   // E4
        n_vec++; if ({alu_irq_clr, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL irq_e4: got %b exp 10", {alu_irq_clr, rsp_valid}); end
        tick();                                   // E5
        n_vec++; if ({alu_irq_clr, rsp_valid} !== 2'b01) begin n_err++; $display("FAIL irq_e5: got %b exp 01", {alu_irq_clr, rsp_valid}); end
        n_vec++; if ({rsp_mode, rsp_op, rsp_irq, rsp_data} !== {1'b0, OP1, 1'b1, 8'hFF}) begin n_err++; $display("FAIL irq_rsp: got %h exp %h", {rsp_mode, rsp_op, rsp_irq, rsp_data}, {1'b0, OP1, 1'b1, 8'hFF}); end
        tick();                                   // E6
        n_vec++; if (clr_hi - c0 !== 2) begin n_err++; $display("FAIL irq_clr_cycles: got %0d exp 2", clr_hi - c0); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL irq_rsp_drop: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_path_b_guard;
        logic [11:0] got;
        bit ok;
        rsp_ready = 1'b1;
        drive(1'b1, OP2, 8'h3C, 8'h0F);
        tick();
        cmd_valid = 1'b0;
        tick();
        n_vec++; if ({alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b} !== {3'b101, OP1, OP2}) begin n_err++; $display("FAIL b2_pins: got %b exp %b", {alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b}, {3'b101, OP1, OP2}); end
        wait_rsp(got, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2_timeout: got no response exp one"); end
        n_vec++; if (got !== {1'b1, OP2, 1'b0, 8'h0C}) begin n_err++; $display("FAIL b2_rsp: got %h exp %h", got, {1'b1, OP2, 1'b0, 8'h0C}); end
        drive(1'b0, OP1, 8'h77, 8'h00);
        tick();
        cmd_valid = 1'b0;
        wait_rsp(got, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL guard_timeout: got no response exp one"); end
        n_vec++; if (got !== {1'b0, OP1, 1'b0, 8'h00}) begin n_err++; $display("FAIL guard_rsp: got %h exp %h", got, {1'b0, OP1, 1'b0, 8'h00}); end
        n_vec++; if (irq_count !== 8'd1) begin n_err++; $display("FAIL guard_irq_count: got %0d exp 1", irq_count); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] got;
        bit ok, acc;
        b2b_mode = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        b2b_op   = '{OP4, OP2, OP3, OP3, OP4, OP1};
        b2b_a    = '{8'h11, 8'hF0, 8'h0F, 8'h01, 8'h55, 8'h10};
        b2b_b    = '{8'h22, 8'h3C, 8'hA0, 8'h02, 8'h0F, 8'h20};
        exp_rsp  = '{{1'b0, OP4, 1'b0, 8'h33}, {1'b0, OP2, 1'b0, 8'h30}, {1'b1, OP3, 1'b0, 8'hAF},
                     {1'b0, OP3, 1'b0, 8'h03}, {1'b1, OP4, 1'b0, 8'hA5}, {1'b0, OP1, 1'b0, 8'h30}};
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(b2b_mode[i], b2b_op[i], b2b_a[i], b2b_b[i]);
            n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got %b exp 1", i, cmd_ready); end
            tick();
        end
        drive(b2b_mode[5], b2b_op[5], b2b_a[5], b2b_b[5]);
        n_vec++; if ({cmd_ready, cmd_count} !== 4'b0100) begin n_err++; $display("FAIL b2b_full: got %b exp 0100", {cmd_ready, cmd_count}); end
        repeat (6) tick();
        n_vec++; if ({cmd_ready, cmd_count} !== 4'b0100) begin n_err++; $display("FAIL b2b_stall: got %b exp 0100", {cmd_ready, cmd_count}); end
        n_vec++; if ({rsp_valid, rsp_data} !== {1'b1, 8'h33}) begin n_err++; $display("FAIL b2b_hold: got %h exp %h", {rsp_valid, rsp_data}, {1'b1, 8'h33}); end
        acc = 1'b0;
        fork
            begin
                for (int k = 0; k < 100; k++) begin
                    if (cmd_ready) begin
                        tick();
                        cmd_valid = 1'b0;
                        acc = 1'b1;
                        break;
                    end
                    tick();
                end
            end
            begin
                rsp_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    wait_rsp(got, ok);
                    n_vec++; if (ok !== 1'b1 || got !== exp_rsp[i]) begin n_err++; $display("FAIL b2b_rsp_%0d: got %h ok %b exp %h", i, got, ok, exp_rsp[i]); end
                end
            end
        join
        cmd_valid = 1'b0;
        n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL b2b_sixth_accept: got %b exp 1", acc); end
    endtask

    task automatic test_reset_clear;
        int v0, e0;
        rsp_ready = 1'b1;
        drive(1'b0, OP1, 8'hFF, 8'hFF);
        tick();                                   // E0
        drive(1'b0, OP4, 8'h01, 8'h02);
        tick();                                   // E1
        cmd_valid = 1'b0;
        repeat (2) tick();                        // E3, first CLEAR cycle
        n_vec++; if ({alu_irq_clr, cmd_count} !== 4'b1001) begin n_err++; $display("FAIL rc_pre: got %b exp 1001", {alu_irq_clr, cmd_count}); end
        #2;
        alu_rst_n = 1'b0;
        #1;
        n_vec++; if ({alu_irq_clr, rsp_valid, busy} !== 3'b000) begin n_err++; $display("FAIL rc_drop: got %b exp 000", {alu_irq_clr, rsp_valid, busy}); end
        n_vec++; if ({cmd_ready, cmd_count, irq_count} !== {1'b1, 3'd0, 8'd0}) begin n_err++; $display("FAIL rc_fifo: got %h exp %h", {cmd_ready, cmd_count, irq_count}, {1'b1, 3'd0, 8'd0}); end
        @(negedge alu_clk);
        alu_rst_n = 1'b1;
        v0 = rv_hi;
        e0 = en_hi;
        repeat (20) tick();
        n_vec++; if (rv_hi - v0 !== 0) begin n_err++; $display("FAIL rc_no_rsp: got %0d exp 0", rv_hi - v0); end
        n_vec++; if ({en_hi - e0 == 0, busy} !== 2'b10) begin n_err++; $display("FAIL rc_idle: got %b exp 10", {en_hi - e0 == 0, busy}); end
    endtask

    initial begin
        test_reset();
        test_path_a_op4();
        test_irq();
        test_path_b_guard();
        test_back_to_back();
        test_reset_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
